// File: rtl/add_pkg.sv
// Shared constants for the calc/add library.
package add_pkg;
   localparam int ADD_GRP_WIDTH = 4;
endpackage

// File: rtl/add_4bit_ahead.sv
// Combinational 4-bit carry-lookahead group; exposes c3 so the top can detect signed overflow.
module add_4bit_ahead
   import add_pkg::*;
(
   input  logic [ADD_GRP_WIDTH-1:0] i_a,
   input  logic [ADD_GRP_WIDTH-1:0] i_b,
   input  logic                     i_c0,
   output logic [ADD_GRP_WIDTH-1:0] o_s,
   output logic                     o_c3,
   output logic                     o_c4
);

   logic [ADD_GRP_WIDTH-1:0] w_p;
   logic [ADD_GRP_WIDTH-1:0] w_g;
   logic [ADD_GRP_WIDTH-1:0] w_c;
   logic                     w_c4;

   assign w_p = i_a ^ i_b;
   assign w_g = i_a & i_b;

   // Each carry is a flat sum of products of the group inputs, not a ripple chain.
   assign w_c[0] = i_c0;
   assign w_c[1] = w_g[0] | (w_p[0] & i_c0);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c0);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_c0);
   assign w_c4   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c0);

   assign o_s  = w_p ^ w_c;
   assign o_c3 = w_c[3];
   assign o_c4 = w_c4;

endmodule

// File: rtl/add_nnbit_ahead_serial_core.sv
// Registered N-bit adder: 4-bit lookahead groups chained serially, one output register stage.
// Optional signed-overflow output o_ovf enabled by defining ADD_AHEAD_SERIAL_OVF_EN.
module add_nnbit_ahead_serial_core
   import add_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_vld,
   input  logic [DATA_WIDTH-1:0] i_num_a,
   input  logic [DATA_WIDTH-1:0] i_num_b,
   input  logic                  i_cry,
`ifdef ADD_AHEAD_SERIAL_OVF_EN
   output logic                  o_ovf,
`endif
   output logic                  o_vld,
   output logic [DATA_WIDTH-1:0] o_res,
   output logic                  o_cry
);

   localparam int NGRP = DATA_WIDTH / ADD_GRP_WIDTH;

   generate
      if ((DATA_WIDTH <= 0) || (DATA_WIDTH % ADD_GRP_WIDTH != 0)) begin : g_bad_width
         $error("DATA_WIDTH must be a positive multiple of 4");
      end
   endgenerate

   logic [NGRP:0]           w_cry_p0;
   logic [NGRP-1:0]         w_c3_p0;
   logic [DATA_WIDTH-1:0]   w_sum_p0;

   assign w_cry_p0[0] = i_cry;

   genvar k;
   generate
      for (k = 0; k < NGRP; k++) begin : g_grp
         add_4bit_ahead u_grp (
            .i_a  (i_num_a[k*ADD_GRP_WIDTH +: ADD_GRP_WIDTH]),
            .i_b  (i_num_b[k*ADD_GRP_WIDTH +: ADD_GRP_WIDTH]),
            .i_c0 (w_cry_p0[k]),
            .o_s  (w_sum_p0[k*ADD_GRP_WIDTH +: ADD_GRP_WIDTH]),
            .o_c3 (w_c3_p0[k]),
            .o_c4 (w_cry_p0[k+1])
         );
      end
   endgenerate

   // ---- p0 -> p1 register boundary ----
   logic                  r_vld_p1;
   logic [DATA_WIDTH-1:0] r_res_p1;
   logic                  r_cry_p1;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_vld_p1 <= 1'b0;
         r_res_p1 <= '0;
         r_cry_p1 <= 1'b0;
      end else begin
         r_vld_p1 <= i_vld;
         if (i_vld) begin
            r_res_p1 <= w_sum_p0;
            r_cry_p1 <= w_cry_p0[NGRP];
         end
      end
   end

`ifdef ADD_AHEAD_SERIAL_OVF_EN
   // Signed overflow: carry into the MSB differs from carry out of it.
   logic r_ovf_p1;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ovf_p1 <= 1'b0;
      end else if (i_vld) begin
         r_ovf_p1 <= w_c3_p0[NGRP-1] ^ w_cry_p0[NGRP];
      end
   end
   assign o_ovf = r_ovf_p1;
`else
   logic w_unused_c3;
   assign w_unused_c3 = ^w_c3_p0;
`endif

   assign o_vld = r_vld_p1;
   assign o_res = r_res_p1;
   assign o_cry = r_cry_p1;

endmodule

// File: tb/tb_add_nnbit_ahead_serial_core.sv
// Directed-vector bench for add_nnbit_ahead_serial_core (8-bit and 16-bit instances).
// Overflow checks are compiled in when ADD_AHEAD_SERIAL_OVF_EN is defined.
module tb_add_nnbit_ahead_serial_core;

   logic        clk;
   logic        rst_n;
   logic        vld;
   logic [7:0]  a, b;
   logic        cin;
   logic        o_vld;
   logic [7:0]  o_res;
   logic        o_cry;
   logic        vld16;
   logic [15:0] a16, b16;
   logic        cin16;
   logic        o_vld16;
   logic [15:0] o_res16;
   logic        o_cry16;
`ifdef ADD_AHEAD_SERIAL_OVF_EN
   logic        o_ovf;
   logic        o_ovf16;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   add_nnbit_ahead_serial_core #(.DATA_WIDTH(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_vld   (vld),
      .i_num_a (a),
      .i_num_b (b),
      .i_cry   (cin),
`ifdef ADD_AHEAD_SERIAL_OVF_EN
      .o_ovf   (o_ovf),
`endif
      .o_vld   (o_vld),
      .o_res   (o_res),
      .o_cry   (o_cry)
   );

   add_nnbit_ahead_serial_core #(.DATA_WIDTH(16)) dut16 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_vld   (vld16),
      .i_num_a (a16),
      .i_num_b (b16),
      .i_cry   (cin16),
`ifdef ADD_AHEAD_SERIAL_OVF_EN
      .o_ovf   (o_ovf16),
`endif
      .o_vld   (o_vld16),
      .o_res   (o_res16),
      .o_cry   (o_cry16)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [7:0] res;
      logic       co;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t vt[10];

   initial begin
      logic [16:0] sum17;
      logic [7:0]  hold_res;
      logic        hold_cry;
      logic        exp_ovf;

      vt[0] = '{8'hF0, 8'hF0, 1'b0, 8'hE0, 1'b1};
      vt[1] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
      vt[2] = '{8'hFC, 8'hF9, 1'b0, 8'hF5, 1'b1};
      vt[3] = '{8'hF7, 8'hF6, 1'b0, 8'hED, 1'b1};
      vt[4] = '{8'hF5, 8'hF5, 1'b1, 8'hEB, 1'b1};
      vt[5] = '{8'hFE, 8'hF9, 1'b1, 8'hF8, 1'b1};
      vt[6] = '{8'hF2, 8'hF6, 1'b1, 8'hE9, 1'b1};
      vt[7] = '{8'hF6, 8'hFC, 1'b1, 8'hF3, 1'b1};
      vt[8] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
      vt[9] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};

      // reset overrides a valid input
      rst_n = 1'b0; vld = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      vld16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
      step(); step();
      check("rst_vld", 32'(o_vld), 32'd0);
      check("rst_res", 32'(o_res), 32'd0);
      check("rst_cry", 32'(o_cry), 32'd0);
`ifdef ADD_AHEAD_SERIAL_OVF_EN
      check("rst_ovf", 32'(o_ovf), 32'd0);
`endif
      vld = 1'b0;
      rst_n = 1'b1;
      step();
      check("idle_vld", 32'(o_vld), 32'd0);

      // back-to-back vectors, each checked one edge after it is sampled
      for (int i = 0; i < 10; i++) begin
         vld = 1'b1; a = vt[i].a; b = vt[i].b; cin = vt[i].c;
         step();
         check($sformatf("vec%0d_vld", i), 32'(o_vld), 32'd1);
         check($sformatf("vec%0d_res", i), 32'(o_res), 32'(vt[i].res));
         check($sformatf("vec%0d_cry", i), 32'(o_cry), 32'(vt[i].co));
      end

      // hold: inputs change while i_vld is low
      hold_res = o_res; hold_cry = o_cry;
      vld = 1'b0; a = 8'h12; b = 8'h34; cin = 1'b1;
      step();
      check("hold_vld", 32'(o_vld), 32'd0);
      check("hold_res", 32'(o_res), 32'(hold_res));
      check("hold_cry", 32'(o_cry), 32'(hold_cry));
      a = 8'hFF; b = 8'h01;
      step();
      check("hold2_res", 32'(o_res), 32'(hold_res));
      check("hold2_cry", 32'(o_cry), 32'(hold_cry));

      // reset mid-stream
      vld = 1'b1; a = 8'h80; b = 8'h90; cin = 1'b0;
      step();
      check("pre_rst_res", 32'(o_res), 32'h10);
      check("pre_rst_cry", 32'(o_cry), 32'd1);
      rst_n = 1'b0;
      step();
      check("mid_rst_vld", 32'(o_vld), 32'd0);
      check("mid_rst_res", 32'(o_res), 32'd0);
      check("mid_rst_cry", 32'(o_cry), 32'd0);
      rst_n = 1'b1; vld = 1'b0;
      step();
      check("post_rst_idle_vld", 32'(o_vld), 32'd0);
      check("post_rst_idle_res", 32'(o_res), 32'd0);
      vld = 1'b1; a = 8'h21; b = 8'h43; cin = 1'b1;
      step();
      check("post_rst_vld", 32'(o_vld), 32'd1);
      check("post_rst_res", 32'(o_res), 32'h65);
      check("post_rst_cry", 32'(o_cry), 32'd0);

`ifdef ADD_AHEAD_SERIAL_OVF_EN
      a = 8'h7F; b = 8'h01; cin = 1'b0;
      step();
      check("ovf1_res", 32'(o_res), 32'h80);
      check("ovf1_cry", 32'(o_cry), 32'd0);
      check("ovf1_ovf", 32'(o_ovf), 32'd1);
      a = 8'h80; b = 8'h80; cin = 1'b0;
      step();
      check("ovf2_res", 32'(o_res), 32'h00);
      check("ovf2_cry", 32'(o_cry), 32'd1);
      check("ovf2_ovf", 32'(o_ovf), 32'd1);
      a = 8'hF0; b = 8'hF0; cin = 1'b0;
      step();
      check("ovf3_ovf", 32'(o_ovf), 32'd0);
      vld = 1'b0; a = 8'h7F; b = 8'h7F;
      step();
      check("ovf_hold", 32'(o_ovf), 32'd0);
`endif
      vld = 1'b0;

      // 16-bit: carry rippling through all four groups
      vld16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1;
      step();
      check("w16_chain_res", 32'(o_res16), 32'h0000);
      check("w16_chain_cry", 32'(o_cry16), 32'd1);
      check("w16_chain_vld", 32'(o_vld16), 32'd1);

      // 16-bit random against behavioural addition
      for (int i = 0; i < 1000; i++) begin
         a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
         sum17 = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
         exp_ovf = (a16[15] == b16[15]) && (sum17[15] != a16[15]);
         step();
         check("rnd_res", 32'(o_res16), 32'(sum17[15:0]));
         check("rnd_cry", 32'(o_cry16), 32'(sum17[16]));
`ifdef ADD_AHEAD_SERIAL_OVF_EN
         check("rnd_ovf", 32'(o_ovf16), 32'(exp_ovf));
`else
         if (exp_ovf === 1'bx) $display("rnd ovf model undefined");
`endif
      end
      vld16 = 1'b0;
      step();
      check("w16_idle_vld", 32'(o_vld16), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
